// File: rtl/hamming_pkg.sv
// Shared definitions for the (7,4) Hamming encoder, decoder and receive
// deserializer, so that every block agrees on codeword widths and states.
package hamming_pkg;

  localparam int CW_LEN = 7;  // codeword length: 4 data + 3 parity bits
  localparam int K_LEN  = 4;  // data bits per codeword

  // Deserializer framing state: waiting for the first sync, or assembling bits.
  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } deser_state_e;

endpackage : hamming_pkg

// File: rtl/sat_counter.sv
// Saturating statistics counter with synchronous clear. The counter sticks at
// all-ones instead of wrapping. When clear and increment arrive together,
// clear wins.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/hamming_rx_deser.sv
// Receive-side deserializer that sits in front of the (7,4) Hamming decoder.
// It gathers serial channel bits into sync-aligned codewords and offers each
// one through a 1-deep valid/ready output register. When a codeword finishes
// while the output register is still full and not being consumed, the new
// codeword is dropped. Saturating counters record delivered and dropped
// codewords.
module hamming_rx_deser #(
  parameter int CW_LEN    = hamming_pkg::CW_LEN,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit REQ_SYNC  = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  input  logic              sync_i,
  input  logic              clr_stats_i,
  output logic [CW_LEN-1:0] cw_o,
  output logic              cw_valid_o,
  input  logic              cw_ready_i,
  output logic [CNT_W-1:0]  cw_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic              ovf_o
);

  import hamming_pkg::*;

  localparam int              IDX_W       = $clog2(CW_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CW_LEN - 1);
  localparam deser_state_e    RESET_STATE = REQ_SYNC ? HUNT : COLLECT;

  deser_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CW_LEN-1:0] sh_q, sh_d;
  logic [CW_LEN-1:0] cw_q, cw_d;
  logic              cw_valid_q, cw_valid_d;
  logic              ovf_q, ovf_d;

  logic              take_bit;
  logic              complete;
  logic              handshake;
  logic              load;
  logic              drop;

  // Framing FSM, bit index and shift register. A sync always restarts the
  // codeword, and a bit arriving with the sync becomes bit 0. The assembled
  // codeword is the shift register value that includes the 7th bit.
  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    complete = 1'b0;
    take_bit = bit_valid_i && ((state_q == COLLECT) || sync_i);

    if (take_bit) begin
      if (LSB_FIRST) begin
        sh_d = {bit_i, sh_q[CW_LEN-1:1]};
      end else begin
        sh_d = {sh_q[CW_LEN-2:0], bit_i};
      end
    end

    if (sync_i) begin
      state_d = COLLECT;
      idx_d   = bit_valid_i ? IDX_W'(1) : '0;
    end else if ((state_q == COLLECT) && bit_valid_i) begin
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        complete = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Output register and overflow flag. A finished codeword loads when the
  // slot is empty or is being emptied on this same cycle. Otherwise the
  // codeword is dropped.
  always_comb begin
    handshake  = cw_valid_q && cw_ready_i;
    load       = complete && (!cw_valid_q || cw_ready_i);
    drop       = complete && cw_valid_q && !cw_ready_i;
    cw_d       = load ? sh_d : cw_q;
    cw_valid_d = load || (cw_valid_q && !cw_ready_i);
    ovf_d      = ovf_q;
    if (clr_stats_i) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // State, datapath and flag registers. Reset also throws away any partial
  // codeword that was being assembled.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the clock edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      idx_q      <= '0;
      sh_q       <= '0;
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      cw_q       <= cw_d;
      cw_valid_q <= cw_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cw_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (handshake),
    .clr_i (clr_stats_i),
    .cnt_o (cw_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (drop),
    .clr_i (clr_stats_i),
    .cnt_o (drop_cnt_o)
  );

  assign cw_o       = cw_q;
  assign cw_valid_o = cw_valid_q;
  assign ovf_o      = ovf_q;

endmodule : hamming_rx_deser

// File: tb/tb_hamming_rx_deser.sv
// Self-checking bench for hamming_rx_deser. The main instance uses the
// default parameters and is compared every cycle against a queue-based
// reference model. A second instance (MSB-first, no sync needed, 3-bit
// counters) checks the bit ordering, free-running start and saturation.
module tb_hamming_rx_deser;

  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bit_i, bit_valid_i, sync_i, clr_stats_i, cw_ready_i;
  logic [6:0]       cw_o;
  logic             cw_valid_o;
  logic [CNT_W-1:0] cw_cnt_o, drop_cnt_o;
  logic             ovf_o;

  logic             s_bit, s_bit_valid, s_ready;
  logic [6:0]       s_cw;
  logic             s_valid;
  logic [2:0]       s_cw_cnt, s_drop_cnt;
  logic             s_ovf;

  always #5 clk = ~clk;

  hamming_rx_deser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .sync_i      (sync_i),
    .clr_stats_i (clr_stats_i),
    .cw_o        (cw_o),
    .cw_valid_o  (cw_valid_o),
    .cw_ready_i  (cw_ready_i),
    .cw_cnt_o    (cw_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
    .ovf_o       (ovf_o)
  );

  hamming_rx_deser #(.LSB_FIRST(1'b0), .REQ_SYNC(1'b0), .CNT_W(3)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_i       (s_bit),
    .bit_valid_i (s_bit_valid),
    .sync_i      (1'b0),
    .clr_stats_i (1'b0),
    .cw_o        (s_cw),
    .cw_valid_o  (s_valid),
    .cw_ready_i  (s_ready),
    .cw_cnt_o    (s_cw_cnt),
    .drop_cnt_o  (s_drop_cnt),
    .ovf_o       (s_ovf)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: received bits since the last boundary, one output slot
  // and the statistics.
  bit       m_bits[$];
  bit       m_collect;
  bit [6:0] m_cw;
  bit       m_valid;
  int       m_cnt, m_drop;
  bit       m_ovf;

  task automatic model_reset();
    m_bits.delete();
    m_collect = 1'b0;
    m_cw      = '0;
    m_valid   = 1'b0;
    m_cnt     = 0;
    m_drop    = 0;
    m_ovf     = 1'b0;
  endtask

  // Applies the inputs that were present at the clock edge that just happened.
  task automatic model_edge();
    bit       hs, done, dropped;
    bit [6:0] nw;
    hs   = m_valid && cw_ready_i;
    done = 1'b0;
    nw   = '0;
    if (m_collect || sync_i) begin
      if (sync_i) begin
        m_bits.delete();
        m_collect = 1'b1;
      end
      if (bit_valid_i) begin
        m_bits.push_back(bit'(bit_i));
        if (m_bits.size() == 7) begin
          done = 1'b1;
          for (int k = 0; k < 7; k++) nw[k] = m_bits[k];
          m_bits.delete();
        end
      end
    end
    dropped = done && m_valid && !hs;
    if (done && !dropped) begin
      m_cw    = nw;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (clr_stats_i) begin
      m_cnt  = 0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (hs && m_cnt < CMAX) m_cnt++;
      if (dropped) begin
        if (m_drop < CMAX) m_drop++;
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model cw_valid_o", 32'(cw_valid_o), 32'(m_valid));
    check("model cw_o", 32'(cw_o), 32'(m_cw));
    check("model cw_cnt_o", 32'(cw_cnt_o), 32'(m_cnt));
    check("model drop_cnt_o", 32'(drop_cnt_o), 32'(m_drop));
    check("model ovf_o", 32'(ovf_o), 32'(m_ovf));
  endtask

  task automatic send(input logic b, input logic s);
    bit_i       = b;
    bit_valid_i = 1'b1;
    sync_i      = s;
    step();
    bit_valid_i = 1'b0;
    sync_i      = 1'b0;
  endtask

  // ser[6] is sent first, so the literal reads left-to-right in time order.
  task automatic send_word(input logic [6:0] ser, input logic with_sync);
    for (int i = 0; i < 7; i++) send(ser[6-i], with_sync && (i == 0));
  endtask

  task automatic clear_stats();
    clr_stats_i = 1'b1;
    step();
    clr_stats_i = 1'b0;
  endtask

  task automatic s_send_word(input logic [6:0] ser);
    for (int i = 0; i < 7; i++) begin
      s_bit       = ser[6-i];
      s_bit_valid = 1'b1;
      step();
      s_bit_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [6:0] ser;  // transmission order, leftmost bit first
    logic [6:0] exp;  // codeword expected on cw_o
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{7'b1101001, 7'b1001011};
    tbl[1] = '{7'b0000000, 7'b0000000};
    tbl[2] = '{7'b1111111, 7'b1111111};
    tbl[3] = '{7'b1000000, 7'b0000001};
    tbl[4] = '{7'b0000001, 7'b1000000};
    tbl[5] = '{7'b1010101, 7'b1010101};
    tbl[6] = '{7'b1110000, 7'b0000111};
    tbl[7] = '{7'b0110010, 7'b0100110};

    rst_n = 1'b0;
    bit_i = 1'b0; bit_valid_i = 1'b0; sync_i = 1'b0; clr_stats_i = 1'b0; cw_ready_i = 1'b0;
    s_bit = 1'b0; s_bit_valid = 1'b0; s_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("reset cw_valid_o", 32'(cw_valid_o), 32'd0);
    check("reset cw_o", 32'(cw_o), 32'd0);
    check("reset cw_cnt_o", 32'(cw_cnt_o), 32'd0);
    check("reset drop_cnt_o", 32'(drop_cnt_o), 32'd0);
    check("reset ovf_o", 32'(ovf_o), 32'd0);

    // Hunting: bits without a sync are ignored.
    for (int i = 0; i < 20; i++) send(1'($urandom), 1'b0);
    check("hunt cw_valid_o", 32'(cw_valid_o), 32'd0);
    check("hunt cw_cnt_o", 32'(cw_cnt_o), 32'd0);
    check("hunt drop_cnt_o", 32'(drop_cnt_o), 32'd0);

    // Basic codeword, valid one cycle after the 7th bit.
    cw_ready_i = 1'b1;
    send_word(7'b1101001, 1'b1);
    check("first cw_valid_o", 32'(cw_valid_o), 32'd1);
    check("first cw_o", 32'(cw_o), 32'h4B);
    step();
    check("first cw_cnt_o", 32'(cw_cnt_o), 32'd1);
    check("first cw_valid_o after hs", 32'(cw_valid_o), 32'd0);

    // Table of ordering vectors.
    for (int v = 0; v < 8; v++) begin
      send_word(tbl[v].ser, 1'b1);
      check($sformatf("tbl[%0d] cw_valid_o", v), 32'(cw_valid_o), 32'd1);
      check($sformatf("tbl[%0d] cw_o", v), 32'(cw_o), 32'(tbl[v].exp));
    end
    step();
    check("tbl cw_cnt_o", 32'(cw_cnt_o), 32'd9);

    // Overflow: the first codeword is held and the second is dropped.
    clear_stats();
    check("clr cw_cnt_o", 32'(cw_cnt_o), 32'd0);
    cw_ready_i = 1'b0;
    send_word(7'b1100101, 1'b1);
    send_word(7'b0011110, 1'b0);
    repeat (3) step();
    check("ovf cw_o held", 32'(cw_o), 32'h53);
    check("ovf cw_valid_o", 32'(cw_valid_o), 32'd1);
    check("ovf drop_cnt_o", 32'(drop_cnt_o), 32'd1);
    check("ovf ovf_o", 32'(ovf_o), 32'd1);
    check("ovf cw_cnt_o before ready", 32'(cw_cnt_o), 32'd0);
    cw_ready_i = 1'b1;
    step();
    check("ovf cw_cnt_o after ready", 32'(cw_cnt_o), 32'd1);
    check("ovf cw_valid_o after ready", 32'(cw_valid_o), 32'd0);

    // Back-to-back: the handshake lands on the 7th-bit cycle of the next word.
    clear_stats();
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < 7; i++) begin
        cw_ready_i = (i == 6);
        send(1'($urandom), (w == 0) && (i == 0));
      end
    end
    cw_ready_i = 1'b1;
    step();
    check("b2b cw_cnt_o", 32'(cw_cnt_o), 32'd10);
    check("b2b drop_cnt_o", 32'(drop_cnt_o), 32'd0);

    // A sync after 3 bits discards the partial codeword.
    clear_stats();
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
    send_word(7'b0110010, 1'b1);
    check("resync cw_o", 32'(cw_o), 32'h26);
    step();
    check("resync drop_cnt_o", 32'(drop_cnt_o), 32'd0);
    check("resync cw_cnt_o", 32'(cw_cnt_o), 32'd1);

    // A sync on the 7th bit discards that codeword and starts a new one.
    clear_stats();
    for (int i = 0; i < 6; i++) send(1'b1, i == 0);
    send(1'b0, 1'b1);
    check("sync7 cw_valid_o", 32'(cw_valid_o), 32'd0);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    check("sync7 cw_o", 32'(cw_o), 32'h6A);
    step();
    check("sync7 drop_cnt_o", 32'(drop_cnt_o), 32'd0);

    // Gaps in bit_valid_i hold the state.
    for (int i = 0; i < 7; i++) begin
      send(7'b1011001 >> (6 - i), i == 0);
      if (i == 5) begin
        repeat (20) step();
        check("gap cw_valid_o", 32'(cw_valid_o), 32'd0);
      end else begin
        repeat (2) step();
      end
    end
    check("gap cw_o", 32'(cw_o), 32'h4D);
    step();

    // Asynchronous reset mid-codeword, with stats and a held codeword pending.
    cw_ready_i = 1'b0;
    send_word(7'b1111111, 1'b1);
    send_word(7'b0000000, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst cw_valid_o", 32'(cw_valid_o), 32'd0);
    check("rst cw_o", 32'(cw_o), 32'd0);
    check("rst cw_cnt_o", 32'(cw_cnt_o), 32'd0);
    check("rst drop_cnt_o", 32'(drop_cnt_o), 32'd0);
    check("rst ovf_o", 32'(ovf_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cw_ready_i = 1'b1;
    send_word(7'b1101001, 1'b0);
    check("rst hunt cw_valid_o", 32'(cw_valid_o), 32'd0);
    send_word(7'b1101001, 1'b1);
    check("rst resume cw_o", 32'(cw_o), 32'h4B);
    step();

    // A clear coinciding with a drop wins.
    cw_ready_i = 1'b0;
    send_word(7'b1100101, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b0);
    clr_stats_i = 1'b1;
    send(1'b1, 1'b0);
    clr_stats_i = 1'b0;
    check("clrdrop drop_cnt_o", 32'(drop_cnt_o), 32'd0);
    check("clrdrop ovf_o", 32'(ovf_o), 32'd0);
    check("clrdrop cw_o held", 32'(cw_o), 32'h53);
    cw_ready_i = 1'b1;
    step();
    check("clrdrop cw_cnt_o", 32'(cw_cnt_o), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit_i       = 1'($urandom);
      bit_valid_i = ($urandom_range(0, 3) != 0);
      sync_i      = ($urandom_range(0, 40) == 0);
      cw_ready_i  = ($urandom_range(0, 2) != 0);
      clr_stats_i = ($urandom_range(0, 200) == 0);
      step();
    end
    bit_valid_i = 1'b0; sync_i = 1'b0; clr_stats_i = 1'b0; cw_ready_i = 1'b1;
    step();

    // MSB-first instance: collects from reset and its counters saturate.
    s_ready = 1'b1;
    s_send_word(7'b1101001);
    check("msb cw_valid_o", 32'(s_valid), 32'd1);
    check("msb cw_o", 32'(s_cw), 32'h69);
    for (int w = 0; w < 8; w++) s_send_word(7'($urandom));
    step();
    check("msb cw_cnt_o saturated", 32'(s_cw_cnt), 32'd7);
    check("msb drop_cnt_o", 32'(s_drop_cnt), 32'd0);
    s_ready = 1'b0;
    for (int w = 0; w < 9; w++) s_send_word(7'($urandom));
    check("msb drop_cnt_o saturated", 32'(s_drop_cnt), 32'd7);
    check("msb ovf_o", 32'(s_ovf), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_hamming_rx_deser
